// File: rtl/mv_vec_loader.sv
// Serial-to-parallel loader for the matrix-vector multiplier: collects six
// elements, publishes them with a toggle strobe, then holds the word stable.
module mv_vec_loader #(
  parameter int unsigned HOLD_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_bit,
  input  logic       flush,
  output logic       in_ready,
  output logic [7:0] vector,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PUBLISH = 2'd1,
    HOLD    = 2'd2
  } state_e;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES);
  localparam logic [2:0] LAST_ELEM = 3'd5;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [5:0] shadow_q, shadow_d;
  logic [5:0] elem_q, elem_d;
  logic       tog_q, tog_d;
  logic [3:0] hold_q, hold_d;
  logic       done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= COLLECT;
      cnt_q    <= '0;
      shadow_q <= '0;
      elem_q   <= '0;
      tog_q    <= 1'b0;
      hold_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      elem_q   <= elem_d;
      tog_q    <= tog_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    elem_d   = elem_q;
    tog_d    = tog_q;
    hold_d   = hold_q;
    done_d   = 1'b0;

    unique case (state_q)
      COLLECT: begin
        // flush takes priority: a simultaneous element is dropped
        if (flush) begin
          cnt_d    = '0;
          shadow_d = '0;
        end else if (in_valid) begin
          shadow_d[cnt_q] = in_bit;
          if (cnt_q == LAST_ELEM) begin
            cnt_d   = '0;
            state_d = PUBLISH;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      PUBLISH: begin
        elem_d  = shadow_q;
        tog_d   = ~tog_q;
        hold_d  = HOLD_LOAD;
        done_d  = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (hold_q == 4'd1) begin
          hold_d  = '0;
          state_d = COLLECT;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  assign in_ready = (state_q == COLLECT);
  assign busy     = (state_q != COLLECT) || (cnt_q != 3'd0);
  assign vector   = {elem_q, 1'b0, tog_q};
  assign done     = done_q;

endmodule

// File: tb/tb_mv_vec_loader.sv
// Self-checking bench for mv_vec_loader: directed frames, flush, reset and
// randomized traffic compared against a queue-based frame model.
module tb_mv_vec_loader;

  localparam int unsigned H = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, in_bit = 1'b0, flush = 1'b0;
  logic       in_ready, busy, done;
  logic [7:0] vector;
  logic       in_valid2 = 1'b0, in_bit2 = 1'b0, flush2 = 1'b0;
  logic       in_ready2, busy2, done2;
  logic [7:0] vector2;

  int total = 0;
  int bad   = 0;

  mv_vec_loader #(.HOLD_CYCLES(H)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .flush(flush),
    .in_ready(in_ready), .vector(vector), .busy(busy), .done(done)
  );

  mv_vec_loader #(.HOLD_CYCLES(2)) dut_h2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_bit(in_bit2), .flush(flush2),
    .in_ready(in_ready2), .vector(vector2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  // Frame model: pending elements in a queue, plus a lockout window of
  // 1+H cycles after the sixth element during which nothing is accepted.
  logic       q[$];
  int         lock;
  bit         pend;
  logic [5:0] pbits;
  logic [7:0] mvec;
  logic       mdone;

  function automatic void model_reset();
    q.delete();
    lock  = 0;
    pend  = 0;
    pbits = '0;
    mvec  = '0;
    mdone = 1'b0;
  endfunction

  function automatic void model_edge(input logic v, input logic b, input logic f);
    mdone = 1'b0;
    if (lock != 0) begin
      if (pend) begin
        mvec  = {pbits, 1'b0, ~mvec[0]};
        pend  = 0;
        mdone = 1'b1;
      end
      lock--;
    end else if (f) begin
      q.delete();
    end else if (v) begin
      q.push_back(b);
      if (q.size() == 6) begin
        for (int k = 0; k < 6; k++) pbits[k] = q[k];
        q.delete();
        lock = 1 + H;
        pend = 1;
      end
    end
  endfunction

  task automatic step(input logic v, input logic b, input logic f);
    in_valid = v;
    in_bit   = b;
    flush    = f;
    @(posedge clk);
    model_edge(v, b, f);
    @(negedge clk);
  endtask

  task automatic step2(input logic v, input logic b);
    in_valid2 = v;
    in_bit2   = b;
    step(1'b0, 1'b0, 1'b0);
    in_valid2 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (vector !== 8'h00) begin bad++; $display("FAIL reset_vector got=%h want=00", vector); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (in_ready2 !== 1'b1) begin bad++; $display("FAIL reset_in_ready2 got=%b want=1", in_ready2); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed_frame();
    logic b6 [6];
    int   low, dones, g;
    b6 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL frame1_ready_e%0d got=%b want=1", i, in_ready); end
      step(1'b1, b6[i], 1'b0);
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL frame1_busy got=%b want=1", busy); end
    low = 0; dones = 0; g = 0;
    while (in_ready !== 1'b1 && g < 12) begin
      low++;
      if (done === 1'b1) begin
        dones++;
        total++; if (vector !== 8'h35) begin bad++; $display("FAIL frame1_vector got=%h want=35", vector); end
      end
      step(1'b0, 1'b0, 1'b0);
      g++;
    end
    total++; if (low != 1 + H) begin bad++; $display("FAIL frame1_ready_low got=%0d want=%0d", low, 1 + H); end
    total++; if (dones != 1) begin bad++; $display("FAIL frame1_done_pulses got=%0d want=1", dones); end
    total++; if (vector !== 8'h35) begin bad++; $display("FAIL frame1_vector_hold got=%h want=35", vector); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL frame1_idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_ones_frame();
    int g;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
    g = 0;
    while (in_ready !== 1'b1 && g < 12) begin
      total++; if (vector[1] !== 1'b0) begin bad++; $display("FAIL ones_bit1 got=%b want=0", vector[1]); end
      step(1'b0, 1'b0, 1'b0);
      g++;
    end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ones_ready_timeout got=%b want=1", in_ready); end
    total++; if (vector !== 8'hFC) begin bad++; $display("FAIL ones_vector got=%h want=fc", vector); end
  endtask

  task automatic test_flush();
    logic b6 [6];
    int   g;
    b6 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom), 1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_pre_busy got=%b want=1", busy); end
    step(1'b1, 1'b1, 1'b1);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b want=0", busy); end
    total++; if (vector !== 8'hFC) begin bad++; $display("FAIL flush_vector_kept got=%h want=fc", vector); end
    for (int i = 0; i < 6; i++) step(1'b1, b6[i], 1'b0);
    g = 0;
    while (in_ready !== 1'b1 && g < 12) begin step(1'b0, 1'b0, 1'b0); g++; end
    total++; if (vector !== 8'h81) begin bad++; $display("FAIL flush_vector got=%h want=81", vector); end
  endtask

  task automatic test_continuous();
    int acc, frames, g;
    acc = 0; frames = 0;
    for (int c = 0; c < 20; c++) begin
      if (in_ready === 1'b1) acc++;
      step(1'b1, 1'b1, 1'b0);
      if (done === 1'b1) frames++;
      total++; if (vector !== mvec) begin bad++; $display("FAIL cont_vector c%0d got=%h want=%h", c, vector, mvec); end
      total++; if (in_ready !== (lock == 0)) begin bad++; $display("FAIL cont_ready c%0d got=%b want=%b", c, in_ready, lock == 0); end
    end
    in_valid = 1'b0;
    total++; if (acc != 12) begin bad++; $display("FAIL cont_accepts got=%0d want=12", acc); end
    total++; if (frames != 2) begin bad++; $display("FAIL cont_frames got=%0d want=2", frames); end
    g = 0;
    while ((lock != 0 || in_ready !== 1'b1) && g < 12) begin step(1'b0, 1'b0, 1'b0); g++; end
  endtask

  task automatic test_random();
    logic v, b, f;
    for (int c = 0; c < 400; c++) begin
      v = ($urandom_range(0, 3) != 0);
      b = 1'($urandom);
      f = ($urandom_range(0, 15) == 0);
      step(v, b, f);
      total++; if (in_ready !== (lock == 0)) begin bad++; $display("FAIL rnd_ready c%0d got=%b want=%b", c, in_ready, lock == 0); end
      total++; if (busy !== (lock != 0 || q.size() != 0)) begin bad++; $display("FAIL rnd_busy c%0d got=%b want=%b", c, busy, (lock != 0 || q.size() != 0)); end
      total++; if (vector !== mvec) begin bad++; $display("FAIL rnd_vector c%0d got=%h want=%h", c, vector, mvec); end
      total++; if (done !== mdone) begin bad++; $display("FAIL rnd_done c%0d got=%b want=%b", c, done, mdone); end
    end
  endtask

  task automatic test_reset_in_hold();
    logic b6 [6];
    int   g;
    b6 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    in_valid = 1'b0; flush = 1'b0;
    rst_n = 1'b0; model_reset();
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, b6[i], 1'b0);
    step(1'b0, 1'b0, 1'b0);
    total++; if (vector !== 8'h35) begin bad++; $display("FAIL rsthold_pre_vector got=%h want=35", vector); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL rsthold_pre_done got=%b want=1", done); end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    total++; if (vector !== 8'h00) begin bad++; $display("FAIL rsthold_vector got=%h want=00", vector); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rsthold_done got=%b want=0", done); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rsthold_ready got=%b want=1", in_ready); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, b6[i], 1'b0);
    step(1'b0, 1'b0, 1'b0);
    total++; if (vector !== 8'h35) begin bad++; $display("FAIL rsthold_post_vector got=%h want=35", vector); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL rsthold_post_done got=%b want=1", done); end
    g = 0;
    while (in_ready !== 1'b1 && g < 12) begin step(1'b0, 1'b0, 1'b0); g++; end
  endtask

  task automatic test_hold2();
    logic [5:0] bits;
    logic [7:0] exp;
    logic [5:0] snap;
    logic       tog;
    int         low, dones, g;
    tog = 1'b0;
    for (int fr = 0; fr < 2; fr++) begin
      bits = 6'($urandom);
      for (int i = 0; i < 6; i++) begin
        total++; if (in_ready2 !== 1'b1) begin bad++; $display("FAIL h2_ready f%0d e%0d got=%b want=1", fr, i, in_ready2); end
        step2(1'b1, bits[i]);
      end
      tog  = ~tog;
      exp  = {bits, 1'b0, tog};
      low  = 0; dones = 0; g = 0; snap = '0;
      while (in_ready2 !== 1'b1 && g < 12) begin
        low++;
        if (done2 === 1'b1) begin dones++; snap = vector2[7:2]; end
        total++; if (busy2 !== 1'b1) begin bad++; $display("FAIL h2_busy f%0d got=%b want=1", fr, busy2); end
        step2(1'b0, 1'b0);
        g++;
      end
      total++; if (low != 3) begin bad++; $display("FAIL h2_ready_low f%0d got=%0d want=3", fr, low); end
      total++; if (dones != 1) begin bad++; $display("FAIL h2_done f%0d got=%0d want=1", fr, dones); end
      total++; if (vector2 !== exp) begin bad++; $display("FAIL h2_vector f%0d got=%h want=%h", fr, vector2, exp); end
      total++; if (vector2[7:2] !== snap) begin bad++; $display("FAIL h2_stable f%0d got=%h want=%h", fr, vector2[7:2], snap); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_directed_frame();
    test_ones_frame();
    test_flush();
    test_continuous();
    test_random();
    test_reset_in_hold();
    test_hold2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
